fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Pipeline sequencer for the fetch/decode front end of the pipelined RV32 core. Owns boot loading of instruction memory through a valid/ready stream. Produces PC_Write, IF_ID_Write and the IF/ID and ID/EX flush controls from branch-taken and load-use inputs. Also sequences halt (drain) and resume, and issues a one-cycle PC redirect to BOOT_PC after every load.

## Interface
- ADDR_WIDTH, 32, PC/byte-address width
- IMEM_DEPTH, 256, instruction memory depth in 32-bit words
- BOOT_PC, 32'h0, PC loaded after a program load
- DRAIN_CYCLES, 3, bubble cycles before HALT is reached
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ld_valid  in  1  loader word valid
- ld_ready  out  1  loader word accepted when ld_valid && ld_ready
- ld_addr  in  ADDR_WIDTH  byte address of loader word
- ld_data  in  32  loader instruction word
- ld_last  in  1  final word of program
- imem_we  out  1  instruction-memory write enable
- imem_waddr  out  ADDR_WIDTH  word index (ld_addr >> 2)
- imem_wdata  out  32  write data (= ld_data)
- PCSrc_E  in  1  branch/jump taken in EX
- load_use_hazard  in  1  load-use hazard detected in ID
- halt_req  in  1  request drain and halt
- resume_req  in  1  request resume from HALT
- PC_Write  out  1  PC register enable
- IF_ID_Write  out  1  IF/ID register enable
- IF_ID_Flush  out  1  load bubble into IF/ID
- ID_EX_Flush  out  1  load bubble into ID/EX
- redirect  out  1  force PC mux to redirect_pc, ORed into the PC select by the integrator
- redirect_pc  out  ADDR_WIDTH  constant BOOT_PC
- halted  out  1  core is in HALT
- loaded_words  out  $clog2(IMEM_DEPTH)+1  words written since entering LOAD, saturating at IMEM_DEPTH
- ld_err  out  1  sticky: a bad load address was seen
- state_o  out  3  LOAD=0, START=1, RUN=2, DRAIN=3, HALT=4

## Operation
States and transitions:
- LOAD: entered on reset.
  - ld_ready=1, PC_Write=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Flush=1.
  - An accepted word with ld_last=1 moves to START.
- START: lasts exactly 1 cycle, then moves to RUN.
  - redirect=1, PC_Write=1, IF_ID_Write=0, both flushes=1.
- RUN: controls follow this priority.
  - PCSrc_E=1: PC_Write=1, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Flush=1. Branch beats load-use.
  - Else load_use_hazard=1: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1.
  - Else: PC_Write=1, IF_ID_Write=1, both flushes 0.
  - halt_req=1 moves to DRAIN and loads drain_cnt=DRAIN_CYCLES.
  - resume_req is ignored.
- DRAIN: PC_Write=0 and IF_ID_Write=1 with IF_ID_Flush=1, inserting bubbles. The PC keeps the address of the next unfetched instruction.
  - PCSrc_E=1: PC_Write=1 (PC takes the target) and ID_EX_Flush=1.
  - load_use_hazard=1 without PCSrc_E: IF_ID_Write=0, ID_EX_Flush=1, and drain_cnt holds.
  - Otherwise drain_cnt decrements each cycle. Moves to HALT when drain_cnt reaches 1 and decrements.
- HALT: halted=1, all four controls 0.
  - ld_valid=1 moves to LOAD.
  - Else resume_req=1 moves to RUN.
  - halt_req is ignored.
  - ld_valid has priority when it arrives together with resume_req.

Loader rules:
- imem_we = ld_valid && ld_ready && addr_ok, where addr_ok means ld_addr[1:0]==0 and ld_addr>>2 < IMEM_DEPTH.
- A bad address is still accepted, but the write is suppressed and ld_err is set.
- ld_err and loaded_words clear on every entry into LOAD. On reset they are 0.
- ld_ready is 0 in every state except LOAD. A word presented in HALT is not accepted until the following cycle, in LOAD.

## Timing
- Control outputs, ld_ready and imem_* are combinational from the state and the current inputs. They take effect in the same cycle.
- State, drain_cnt, loaded_words and ld_err are registered.
- During reset and in the first cycle after it: state=LOAD, ld_ready=1, PC_Write=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Flush=1, redirect=0, halted=0, loaded_words=0, ld_err=0.
- Latencies:
  - Accepted ld_last to START: 1 cycle.
  - START to RUN: 1 cycle.
  - halt_req to halted=1: DRAIN_CYCLES+1 cycles, plus any load-use hold cycles.
  - resume_req to RUN with PC_Write=1: 1 cycle.
- Asserting rst_n low mid-operation, including mid-load, returns immediately to LOAD. Partially loaded memory contents are not cleared.

## Test plan
- Reset, then load 4 words at addresses 0,4,8,12 with ld_last on the 4th. Required: imem_we on 4 cycles with waddr 0..3, loaded_words=4, START for 1 cycle with redirect=1 and redirect_pc=BOOT_PC, then RUN with PC_Write=IF_ID_Write=1.
- Load words at addresses 0x2 and 0x400 (with IMEM_DEPTH=256). Required: both are accepted, imem_we=0 for both, ld_err=1 and stays set until the next LOAD entry.
- In RUN, assert load_use_hazard for 1 cycle, and separately assert it together with PCSrc_E. Required: the first gives PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1. The second gives PC_Write=1 with both flushes=1.
- In RUN, pulse halt_req. Required: DRAIN for 3 cycles with IF_ID_Flush=1 and PC_Write=0, halted=1 on the 4th cycle. A load_use_hazard during DRAIN extends the drain by 1 cycle.
- In HALT, assert resume_req and ld_valid together. Required: next state LOAD. Then assert resume_req alone from HALT: next state RUN.
- Assert rst_n low in the middle of a load. Required: immediate return to LOAD with loaded_words=0 and ld_err=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: front-end pipeline sequencer for the RV32 core.
// Boot-loads instruction memory over a valid/ready stream, then drives the
// PC/IF-ID enables and IF/ID, ID/EX flushes from branch and load-use inputs,
// and sequences drain-to-halt and resume.
module fetch_sequencer #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    IMEM_DEPTH   = 256,
    parameter logic [ADDR_WIDTH-1:0] BOOT_PC      = '0,
    parameter int                    DRAIN_CYCLES = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ld_valid,
    output logic                          ld_ready,
    input  logic [ADDR_WIDTH-1:0]         ld_addr,
    input  logic [31:0]                   ld_data,
    input  logic                          ld_last,
    output logic                          imem_we,
    output logic [ADDR_WIDTH-1:0]         imem_waddr,
    output logic [31:0]                   imem_wdata,
    input  logic                          PCSrc_E,
    input  logic                          load_use_hazard,
    input  logic                          halt_req,
    input  logic                          resume_req,
    output logic                          PC_Write,
    output logic                          IF_ID_Write,
    output logic                          IF_ID_Flush,
    output logic                          ID_EX_Flush,
    output logic                          redirect,
    output logic [ADDR_WIDTH-1:0]         redirect_pc,
    output logic                          halted,
    output logic [$clog2(IMEM_DEPTH):0]   loaded_words,
    output logic                          ld_err,
    output logic [2:0]                    state_o
);

    localparam int LW_W = $clog2(IMEM_DEPTH) + 1;
    localparam int DC_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(IMEM_DEPTH);
    localparam logic [LW_W-1:0]       LW_MAX  = LW_W'(IMEM_DEPTH);
    localparam logic [DC_W-1:0]       DC_INIT = DC_W'(DRAIN_CYCLES);
    localparam logic [DC_W-1:0]       DC_ONE  = DC_W'(1);

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_START = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t                  state;
    logic [DC_W-1:0]         drain_cnt;
    logic [ADDR_WIDTH-1:0]   word_idx;
    logic                    addr_ok;
    logic                    accept;
    logic                    drain_hold;

    assign word_idx    = ld_addr >> 2;
    assign addr_ok     = (ld_addr[1:0] == 2'b00) && (word_idx < DEPTH_A);
    assign ld_ready    = (state == S_LOAD);
    assign accept      = ld_valid && ld_ready;
    assign imem_we     = accept && addr_ok;
    assign imem_waddr  = word_idx;
    assign imem_wdata  = ld_data;
    assign redirect    = (state == S_START);
    assign redirect_pc = BOOT_PC;
    assign halted      = (state == S_HALT);
    assign state_o     = state;

    // A load-use stall in DRAIN freezes the bubble count unless a branch overrides it.
    assign drain_hold  = load_use_hazard && !PCSrc_E;

    // Pipeline enables and flushes, decoded from state and same-cycle hazards.
    always_comb begin
        PC_Write    = 1'b0;
        IF_ID_Write = 1'b0;
        IF_ID_Flush = 1'b0;
        ID_EX_Flush = 1'b0;
        case (state)
            S_LOAD: begin
                IF_ID_Flush = 1'b1;
                ID_EX_Flush = 1'b1;
            end
            S_START: begin
                PC_Write    = 1'b1;
                IF_ID_Flush = 1'b1;
                ID_EX_Flush = 1'b1;
            end
            S_RUN: begin
                if (PCSrc_E) begin
                    PC_Write    = 1'b1;
                    IF_ID_Write = 1'b1;
                    IF_ID_Flush = 1'b1;
                    ID_EX_Flush = 1'b1;
                end else if (load_use_hazard) begin
                    ID_EX_Flush = 1'b1;
                end else begin
                    PC_Write    = 1'b1;
                    IF_ID_Write = 1'b1;
                end
            end
            S_DRAIN: begin
                IF_ID_Flush = 1'b1;
                IF_ID_Write = 1'b1;
                if (PCSrc_E) begin
                    PC_Write    = 1'b1;
                    ID_EX_Flush = 1'b1;
                end else if (load_use_hazard) begin
                    IF_ID_Write = 1'b0;
                    ID_EX_Flush = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // State sequencing plus the loader bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_LOAD;
            drain_cnt    <= '0;
            loaded_words <= '0;
            ld_err       <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (imem_we && (loaded_words != LW_MAX))
                        loaded_words <= loaded_words + LW_W'(1);
                    if (accept && !addr_ok)
                        ld_err <= 1'b1;
                    if (accept && ld_last)
                        state <= S_START;
                end
                S_START: state <= S_RUN;
                S_RUN: begin
                    if (halt_req) begin
                        state     <= S_DRAIN;
                        drain_cnt <= DC_INIT;
                    end
                end
                S_DRAIN: begin
                    if (!drain_hold) begin
                        if (drain_cnt <= DC_ONE)
                            state <= S_HALT;
                        else
                            drain_cnt <= drain_cnt - DC_ONE;
                    end
                end
                S_HALT: begin
                    // Loader wins over resume; LOAD entry clears loader status.
                    if (ld_valid) begin
                        state        <= S_LOAD;
                        loaded_words <= '0;
                        ld_err       <= 1'b0;
                    end else if (resume_req) begin
                        state <= S_RUN;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: the driver queues hand-computed
// per-cycle expectations and expected memory writes; a monitor pops them.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic        PCSrc_E;
    logic        load_use_hazard;
    logic        halt_req;
    logic        resume_req;
    logic        PC_Write;
    logic        IF_ID_Write;
    logic        IF_ID_Flush;
    logic        ID_EX_Flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halted;
    logic [8:0]  loaded_words;
    logic        ld_err;
    logic [2:0]  state_o;

    fetch_sequencer #(
        .ADDR_WIDTH  (32),
        .IMEM_DEPTH  (256),
        .BOOT_PC     (32'h0),
        .DRAIN_CYCLES(3)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .ld_addr        (ld_addr),
        .ld_data        (ld_data),
        .ld_last        (ld_last),
        .imem_we        (imem_we),
        .imem_waddr     (imem_waddr),
        .imem_wdata     (imem_wdata),
        .PCSrc_E        (PCSrc_E),
        .load_use_hazard(load_use_hazard),
        .halt_req       (halt_req),
        .resume_req     (resume_req),
        .PC_Write       (PC_Write),
        .IF_ID_Write    (IF_ID_Write),
        .IF_ID_Flush    (IF_ID_Flush),
        .ID_EX_Flush    (ID_EX_Flush),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .loaded_words   (loaded_words),
        .ld_err         (ld_err),
        .state_o        (state_o)
    );

    localparam logic [2:0] LOAD = 3'd0, START = 3'd1, RUN = 3'd2, DRAIN = 3'd3, HALT = 3'd4;

    // Control bundle: {ld_ready, PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, redirect, halted}
    localparam logic [6:0] C_LOAD     = 7'b1_0_0_1_1_0_0;
    localparam logic [6:0] C_START    = 7'b0_1_0_1_1_1_0;
    localparam logic [6:0] C_RUN      = 7'b0_1_1_0_0_0_0;
    localparam logic [6:0] C_RUN_BR   = 7'b0_1_1_1_1_0_0;
    localparam logic [6:0] C_RUN_LU   = 7'b0_0_0_0_1_0_0;
    localparam logic [6:0] C_DRAIN    = 7'b0_0_1_1_0_0_0;
    localparam logic [6:0] C_DRAIN_LU = 7'b0_0_0_1_1_0_0;
    localparam logic [6:0] C_DRAIN_BR = 7'b0_1_1_1_1_0_0;
    localparam logic [6:0] C_HALT     = 7'b0_0_0_0_0_0_1;

    typedef struct {
        string      tag;
        logic [2:0] st;
        logic [6:0] ctl;
        logic [8:0] lw;
        logic       err;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    exp_t eq[$];
    wr_t  wq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected end of stimulus");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input string tag, input logic [2:0] st, input logic [6:0] ctl,
                       input int lw, input logic err);
        exp_t e;
        e.tag = tag; e.st = st; e.ctl = ctl; e.lw = 9'(lw); e.err = err;
        eq.push_back(e);
        @(negedge clk);
    endtask

    task automatic wr(input int idx, input logic [31:0] d);
        wr_t w;
        w.a = 32'(idx); w.d = d;
        wq.push_back(w);
    endtask

    task automatic word(input logic [31:0] a, input logic [31:0] d, input logic last);
        ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_last = last;
    endtask

    // Monitor: samples 2 time units after each falling edge.
    initial begin
        exp_t        e;
        wr_t         w;
        logic [6:0]  got;
        forever begin
            @(negedge clk);
            #2;
            if (imem_we) begin
                n_tests++;
                if (wq.size() == 0) begin
                    n_fail++;
                    $display("FAIL imem_write: got write waddr=%0h wdata=%h, required no write",
                             imem_waddr, imem_wdata);
                end else begin
                    w = wq.pop_front();
                    if (imem_waddr !== w.a || imem_wdata !== w.d) begin
                        n_fail++;
                        $display("FAIL imem_write: got waddr=%0h wdata=%h, required waddr=%0h wdata=%h",
                                 imem_waddr, imem_wdata, w.a, w.d);
                    end
                end
            end
            if (redirect === 1'b1) begin
                n_tests++;
                if (redirect_pc !== 32'h0) begin
                    n_fail++;
                    $display("FAIL redirect_pc: got %h, required 00000000", redirect_pc);
                end
            end
            if (eq.size() != 0) begin
                e = eq.pop_front();
                got = {ld_ready, PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, redirect, halted};
                n_tests++;
                if (state_o !== e.st || got !== e.ctl || loaded_words !== e.lw || ld_err !== e.err) begin
                    n_fail++;
                    $display("FAIL %s: got state=%0d ctl=%b lw=%0d err=%b, required state=%0d ctl=%b lw=%0d err=%b",
                             e.tag, state_o, got, loaded_words, ld_err, e.st, e.ctl, e.lw, e.err);
                end
            end
        end
    end

    // Driver: inputs change right after each falling edge.
    initial begin
        rst_n = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_last = 1'b0;
        PCSrc_E = 1'b0; load_use_hazard = 1'b0; halt_req = 1'b0; resume_req = 1'b0;
        @(negedge clk);
        cyc("in_reset", LOAD, C_LOAD, 0, 0);
        rst_n = 1'b1;
        cyc("after_reset", LOAD, C_LOAD, 0, 0);

        // Boot load of four words
        for (int i = 0; i < 4; i++) begin
            word(32'(4 * i), 32'hA000_0000 + 32'(i), (i == 3));
            wr(i, 32'hA000_0000 + 32'(i));
            cyc("load4", LOAD, C_LOAD, i, 0);
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        cyc("start", START, C_START, 4, 0);
        cyc("run", RUN, C_RUN, 4, 0);

        // Hazard priority in RUN
        load_use_hazard = 1'b1;
        cyc("run_load_use", RUN, C_RUN_LU, 4, 0);
        load_use_hazard = 1'b0;
        cyc("run_after_lu", RUN, C_RUN, 4, 0);
        load_use_hazard = 1'b1; PCSrc_E = 1'b1;
        cyc("run_branch_beats_lu", RUN, C_RUN_BR, 4, 0);
        load_use_hazard = 1'b0; PCSrc_E = 1'b0;
        resume_req = 1'b1;
        cyc("run_resume_ignored", RUN, C_RUN, 4, 0);
        resume_req = 1'b0;

        // Plain drain to halt
        halt_req = 1'b1;
        cyc("halt_req", RUN, C_RUN, 4, 0);
        halt_req = 1'b0;
        cyc("drain1", DRAIN, C_DRAIN, 4, 0);
        cyc("drain2", DRAIN, C_DRAIN, 4, 0);
        cyc("drain3", DRAIN, C_DRAIN, 4, 0);
        halt_req = 1'b1;
        cyc("halted", HALT, C_HALT, 4, 0);
        halt_req = 1'b0; resume_req = 1'b1;
        cyc("halt_req_ignored", HALT, C_HALT, 4, 0);
        resume_req = 1'b0;
        cyc("resumed_run", RUN, C_RUN, 4, 0);

        // Drain extended by a load-use stall; a branch still decrements
        halt_req = 1'b1;
        cyc("halt_req2", RUN, C_RUN, 4, 0);
        halt_req = 1'b0; load_use_hazard = 1'b1;
        cyc("drain_lu_hold", DRAIN, C_DRAIN_LU, 4, 0);
        load_use_hazard = 1'b0;
        cyc("drain_a", DRAIN, C_DRAIN, 4, 0);
        PCSrc_E = 1'b1;
        cyc("drain_branch", DRAIN, C_DRAIN_BR, 4, 0);
        PCSrc_E = 1'b0;
        cyc("drain_b", DRAIN, C_DRAIN, 4, 0);

        // HALT with ld_valid and resume_req together: loader wins, word not taken yet
        word(32'h10, 32'hB000_0001, 1'b0);
        resume_req = 1'b1;
        cyc("halted_lu_ext", HALT, C_HALT, 4, 0);
        resume_req = 1'b0;
        word(32'h2, 32'hDEAD_0002, 1'b0);
        cyc("load_bad_misalign", LOAD, C_LOAD, 0, 0);
        word(32'h400, 32'hDEAD_0400, 1'b0);
        cyc("load_bad_range", LOAD, C_LOAD, 0, 1);
        word(32'h10, 32'hB000_0001, 1'b0);
        wr(4, 32'hB000_0001);
        cyc("load_good_a", LOAD, C_LOAD, 0, 1);
        word(32'h14, 32'hB000_0002, 1'b1);
        wr(5, 32'hB000_0002);
        cyc("load_good_b", LOAD, C_LOAD, 1, 1);
        ld_valid = 1'b0; ld_last = 1'b0;
        cyc("start2", START, C_START, 2, 1);
        cyc("run2_err_sticky", RUN, C_RUN, 2, 1);

        // Back to HALT, then LOAD entry clears ld_err
        halt_req = 1'b1;
        cyc("halt_req3", RUN, C_RUN, 2, 1);
        halt_req = 1'b0;
        cyc("drain3_1", DRAIN, C_DRAIN, 2, 1);
        cyc("drain3_2", DRAIN, C_DRAIN, 2, 1);
        cyc("drain3_3", DRAIN, C_DRAIN, 2, 1);
        word(32'h20, 32'hC000_0008, 1'b0);
        cyc("halted3_word_held", HALT, C_HALT, 2, 1);
        wr(8, 32'hC000_0008);
        cyc("load3_entry_clears", LOAD, C_LOAD, 0, 0);
        word(32'h3, 32'hDEAD_0003, 1'b0);
        cyc("load3_bad", LOAD, C_LOAD, 1, 0);
        word(32'h24, 32'hC000_0009, 1'b0);
        wr(9, 32'hC000_0009);
        cyc("load3_good", LOAD, C_LOAD, 1, 1);

        // Reset in the middle of the load
        ld_valid = 1'b0; rst_n = 1'b0;
        cyc("reset_mid_load", LOAD, C_LOAD, 0, 0);
        rst_n = 1'b1;
        cyc("after_mid_reset", LOAD, C_LOAD, 0, 0);
        word(32'h0, 32'hD000_0000, 1'b1);
        wr(0, 32'hD000_0000);
        cyc("reload_single", LOAD, C_LOAD, 0, 0);
        ld_valid = 1'b0; ld_last = 1'b0;
        cyc("start4", START, C_START, 1, 0);
        cyc("run4", RUN, C_RUN, 1, 0);

        #3;
        n_tests++;
        if (eq.size() != 0 || wq.size() != 0) begin
            n_fail++;
            $display("FAIL queues_drained: got %0d expectations and %0d writes pending, required 0 and 0",
                     eq.size(), wq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
